// File: rtl/ryu_anim_controller.sv
`default_nettype none
// ============================================================================
// Module      : ryu_anim_controller
// Description : Per-frame sequencer for the Ryu fighter sprite. Owns the
//               sprite position, the current animation (idle, walk, punch,
//               kick) and the animation frame index. State advances only on
//               the rising edge of frame_tick, so the renderer never sees a
//               change in the middle of a scan.
//
// Ports
//   vga_clk     in   1  system clock, rising edge
//   Reset       in   1  asynchronous, active-high reset
//   frame_tick  in   1  level frame strobe; each rising edge is one tick
//   move_left   in   1  walk-left request (level)
//   move_right  in   1  walk-right request (level)
//   punch_req   in   1  punch request (level)
//   kick_req    in   1  kick request (level)
//   RyuX        out 10  sprite left edge
//   RyuY        out 10  sprite top edge (constant)
//   sprite_sel  out  2  0 = IDLE, 1 = WALK, 2 = PUNCH, 3 = KICK
//   frame_idx   out  2  animation frame within the current sprite
//   busy        out  1  high while a punch or kick is playing
//   act_ack     out  1  one-cycle pulse when an action request is accepted
//
// Revision    : 1.0 - initial release
// ============================================================================
module ryu_anim_controller #(
  parameter int X_INIT       = 100,
  parameter int Y_INIT       = 250,
  parameter int X_MIN        = 0,
  parameter int X_MAX        = 527,
  parameter int STEP         = 2,
  parameter int HOLD         = 6,
  parameter int IDLE_FRAMES  = 4,
  parameter int WALK_FRAMES  = 4,
  parameter int PUNCH_FRAMES = 3,
  parameter int KICK_FRAMES  = 4
) (
  input  logic       vga_clk,
  input  logic       Reset,
  input  logic       frame_tick,
  input  logic       move_left,
  input  logic       move_right,
  input  logic       punch_req,
  input  logic       kick_req,
  output logic [9:0] RyuX,
  output logic [9:0] RyuY,
  output logic [1:0] sprite_sel,
  output logic [1:0] frame_idx,
  output logic       busy,
  output logic       act_ack
);

  localparam int HOLD_W = (HOLD > 1) ? $clog2(HOLD) : 1;

  localparam logic [HOLD_W-1:0] C_HOLD_LAST = HOLD_W'(HOLD - 1);
  localparam logic [10:0]       C_X_MAX_W   = 11'(X_MAX);
  localparam logic [10:0]       C_STEP_W    = 11'(STEP);
  localparam logic [9:0]        C_X_MIN_V   = 10'(X_MIN);
  localparam logic [9:0]        C_X_MAX_V   = 10'(X_MAX);
  localparam logic [9:0]        C_X_INIT_V  = 10'(X_INIT);
  localparam logic [9:0]        C_Y_INIT_V  = 10'(Y_INIT);

  // Encoding doubles as the sprite_sel output.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WALK  = 2'd1,
    ST_PUNCH = 2'd2,
    ST_KICK  = 2'd3
  } state_t;

  state_t            state_q,      state_d;
  logic [9:0]        x_q,          x_d;
  logic [1:0]        frame_q,      frame_d;
  logic [HOLD_W-1:0] hold_q,       hold_d;
  logic              busy_q,       busy_d;
  logic              ack_q,        ack_d;
  logic              punch_pend_q, punch_pend_d;
  logic              kick_pend_q,  kick_pend_d;
  logic              tick_prev_q,  tick_prev_d;

  logic              tick;
  logic              can_capture;
  logic [10:0]       x_ext;
  logic [10:0]       x_plus;
  logic [10:0]       x_minus;
  logic              right_sat;
  logic              left_sat;
  state_t            move_state;
  logic [1:0]        last_frame;

  // Index of the final frame of each animation loop.
  function automatic logic [1:0] frames_last(input state_t s);
    logic [1:0] r;
    case (s)
      ST_IDLE:  r = 2'(IDLE_FRAMES - 1);
      ST_WALK:  r = 2'(WALK_FRAMES - 1);
      ST_PUNCH: r = 2'(PUNCH_FRAMES - 1);
      ST_KICK:  r = 2'(KICK_FRAMES - 1);
      default:  r = 2'd0;
    endcase
    return r;
  endfunction

  // Position arithmetic at 11 bits: the extra bit catches overflow past
  // X_MAX on the way up and acts as the borrow flag on the way down.
  always_comb begin
    x_ext     = {1'b0, x_q};
    x_plus    = x_ext + C_STEP_W;
    x_minus   = x_ext - C_STEP_W;
    right_sat = (x_plus > C_X_MAX_W);
    left_sat  = x_minus[10] | (x_minus[9:0] < C_X_MIN_V);
  end

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    frame_d      = frame_q;
    hold_d       = hold_q;
    busy_d       = busy_q;
    ack_d        = 1'b0;
    punch_pend_d = punch_pend_q;
    kick_pend_d  = kick_pend_q;
    tick_prev_d  = frame_tick;
    move_state   = state_q;
    last_frame   = frames_last(state_q);

    tick = frame_tick & ~tick_prev_q;

    // Request capture runs every cycle. Only one action can be pending,
    // and nothing is latched while an action is already playing.
    can_capture = ((state_q == ST_IDLE) || (state_q == ST_WALK)) &&
                  !punch_pend_q && !kick_pend_q;
    if (can_capture) begin
      if (punch_req) begin
        punch_pend_d = 1'b1;
        ack_d        = 1'b1;
      end else if (kick_req) begin
        kick_pend_d = 1'b1;
        ack_d       = 1'b1;
      end
    end

    if (tick) begin
      case (state_q)
        ST_IDLE, ST_WALK: begin
          if (punch_pend_q || kick_pend_q) begin
            state_d      = punch_pend_q ? ST_PUNCH : ST_KICK;
            punch_pend_d = 1'b0;
            kick_pend_d  = 1'b0;
            frame_d      = 2'd0;
            hold_d       = '0;
            busy_d       = 1'b1;
          end else begin
            if (move_right && !move_left) begin
              x_d        = right_sat ? C_X_MAX_V : x_plus[9:0];
              move_state = ST_WALK;
            end else if (move_left && !move_right) begin
              x_d        = left_sat ? C_X_MIN_V : x_minus[9:0];
              move_state = ST_WALK;
            end else begin
              move_state = ST_IDLE;
            end
            state_d = move_state;

            // Switching loops restarts the animation from its first frame.
            if (move_state != state_q) begin
              frame_d = 2'd0;
              hold_d  = '0;
            end else if (hold_q == C_HOLD_LAST) begin
              hold_d  = '0;
              frame_d = (frame_q == last_frame) ? 2'd0 : frame_q + 2'd1;
            end else begin
              hold_d = hold_q + HOLD_W'(1);
            end
          end
        end

        ST_PUNCH, ST_KICK: begin
          // One-shot: the last hold period of the last frame returns to idle.
          if (hold_q == C_HOLD_LAST) begin
            hold_d = '0;
            if (frame_q == last_frame) begin
              state_d = ST_IDLE;
              frame_d = 2'd0;
              busy_d  = 1'b0;
            end else begin
              frame_d = frame_q + 2'd1;
            end
          end else begin
            hold_d = hold_q + HOLD_W'(1);
          end
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // tick_prev resets high so a strobe already asserted at reset release
  // does not register as a tick.
  always_ff @(posedge vga_clk or posedge Reset) begin
    if (Reset) begin
      state_q      <= ST_IDLE;
      x_q          <= C_X_INIT_V;
      frame_q      <= 2'd0;
      hold_q       <= '0;
      busy_q       <= 1'b0;
      ack_q        <= 1'b0;
      punch_pend_q <= 1'b0;
      kick_pend_q  <= 1'b0;
      tick_prev_q  <= 1'b1;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      frame_q      <= frame_d;
      hold_q       <= hold_d;
      busy_q       <= busy_d;
      ack_q        <= ack_d;
      punch_pend_q <= punch_pend_d;
      kick_pend_q  <= kick_pend_d;
      tick_prev_q  <= tick_prev_d;
    end
  end

  assign RyuX       = x_q;
  assign RyuY       = C_Y_INIT_V;
  assign sprite_sel = state_q;
  assign frame_idx  = frame_q;
  assign busy       = busy_q;
  assign act_ack    = ack_q;

endmodule
`default_nettype wire

// File: tb/tb_ryu_anim_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_ryu_anim_controller
// Description : Scoreboard bench for ryu_anim_controller. Stimulus pushes the
//               expected sprite state for every frame tick it issues and the
//               expected acks for every request that should be accepted;
//               independent monitors pop and compare.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ryu_anim_controller;

  logic       clk;
  logic       rst;
  logic       frame_tick;
  logic       move_left;
  logic       move_right;
  logic       punch_req;
  logic       kick_req;
  logic [9:0] ryu_x;
  logic [9:0] ryu_y;
  logic [1:0] sprite_sel;
  logic [1:0] frame_idx;
  logic       busy;
  logic       act_ack;

  ryu_anim_controller dut (
    .vga_clk    (clk),
    .Reset      (rst),
    .frame_tick (frame_tick),
    .move_left  (move_left),
    .move_right (move_right),
    .punch_req  (punch_req),
    .kick_req   (kick_req),
    .RyuX       (ryu_x),
    .RyuY       (ryu_y),
    .sprite_sel (sprite_sel),
    .frame_idx  (frame_idx),
    .busy       (busy),
    .act_ack    (act_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit    chk;
    int    x;
    int    sel;
    int    fidx;
    int    busy;
    string tag;
  } exp_t;

  exp_t  sb_q[$];
  string ack_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Tick monitor: follows the strobe edge the same way the design should
  // and compares outputs one step after every tick edge.
  logic prev_ft;
  logic is_tick;
  exp_t e;
  initial begin
    prev_ft = 1'b1;
    forever begin
      @(posedge clk);
      if (rst) begin
        prev_ft = 1'b1;
      end else begin
        is_tick = frame_tick && !prev_ft;
        prev_ft = frame_tick;
        if (is_tick) begin
          #1;
          if (sb_q.size() == 0) begin
            check("sb_underflow", 32'd0, 32'd1);
          end else begin
            e = sb_q.pop_front();
            if (e.chk) begin
              check($sformatf("%s.RyuX", e.tag),       ryu_x,      e.x);
              check($sformatf("%s.RyuY", e.tag),       ryu_y,      250);
              check($sformatf("%s.sprite_sel", e.tag), sprite_sel, e.sel);
              check($sformatf("%s.frame_idx", e.tag),  frame_idx,  e.fidx);
              check($sformatf("%s.busy", e.tag),       busy,       e.busy);
            end
          end
        end
      end
    end
  end

  // Ack monitor: every ack must be expected and last a single cycle.
  logic prev_ack;
  initial begin
    prev_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (act_ack === 1'b1) begin
        check("ack_width", {31'd0, prev_ack}, 32'd0);
        check("ack_expected", (ack_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
        if (ack_q.size() > 0) void'(ack_q.pop_front());
      end
      prev_ack = act_ack;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic do_tick(input int hi, input bit chk, input int x, input int sel,
                         input int fidx, input int bsy, input string tag);
    exp_t t;
    t.chk = chk; t.x = x; t.sel = sel; t.fidx = fidx; t.busy = bsy; t.tag = tag;
    sb_q.push_back(t);
    @(negedge clk);
    frame_tick = 1'b1;
    repeat (hi) @(negedge clk);
    frame_tick = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_req(input bit p, input bit k, input bit expect_ack, input string tag);
    if (expect_ack) ack_q.push_back(tag);
    @(negedge clk);
    punch_req = p;
    kick_req  = k;
    @(negedge clk);
    punch_req = 1'b0;
    kick_req  = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic punch_body(input string tag);
    for (int m = 1; m <= 18; m++) begin
      if (m < 18) do_tick(1, 1, 0, 2, m / 6, 1, tag);
      else        do_tick(1, 1, 0, 0, 0, 0, tag);
    end
  endtask

  initial begin
    rst        = 1'b1;
    frame_tick = 1'b0;
    move_left  = 1'b0;
    move_right = 1'b0;
    punch_req  = 1'b0;
    kick_req   = 1'b0;
    repeat (3) @(negedge clk);
    check("rst.RyuX", ryu_x, 100);
    check("rst.RyuY", ryu_y, 250);
    check("rst.sprite_sel", sprite_sel, 0);
    check("rst.frame_idx", frame_idx, 0);
    check("rst.busy", busy, 0);
    check("rst.act_ack", act_ack, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Idle pulse: frame advances every 6 ticks, wraps after 24.
    for (int k = 1; k <= 24; k++) do_tick(1, 1, 100, 0, (k / 6) % 4, 0, "idle");

    // Walk right for 10 ticks.
    move_right = 1'b1;
    for (int k = 1; k <= 10; k++) do_tick(1, 1, 100 + 2 * k, 1, (k - 1) / 6, 0, "walk_r");
    move_right = 1'b0;
    do_tick(1, 1, 120, 0, 0, 0, "stop");

    // Right edge saturation.
    move_right = 1'b1;
    for (int k = 1; k <= 202; k++) do_tick(1, 0, 0, 0, 0, 0, "run_r");
    do_tick(1, 1, 526, 1, 1, 0, "edge_r526");
    do_tick(1, 1, 527, 1, 1, 0, "edge_r527");
    do_tick(1, 1, 527, 1, 2, 0, "edge_r_hold1");
    do_tick(1, 1, 527, 1, 2, 0, "edge_r_hold2");

    // Left edge saturation; walk loop continues without restart.
    move_right = 1'b0;
    move_left  = 1'b1;
    for (int j = 1; j <= 262; j++) do_tick(1, 0, 0, 0, 0, 0, "run_l");
    do_tick(1, 1, 1, 1, 2, 0, "edge_l1");
    do_tick(1, 1, 0, 1, 2, 0, "edge_l0");
    do_tick(1, 1, 0, 1, 2, 0, "edge_l_hold");
    move_left = 1'b0;
    do_tick(1, 1, 0, 0, 0, 0, "stop_l");

    // Punch; a kick request mid-punch is ignored.
    pulse_req(1'b1, 1'b0, 1'b1, "punch");
    do_tick(1, 1, 0, 2, 0, 1, "punch_start");
    for (int m = 1; m <= 18; m++) begin
      if (m < 18) do_tick(1, 1, 0, 2, m / 6, 1, "punch");
      else        do_tick(1, 1, 0, 0, 0, 0, "punch_end");
      if (m == 3) pulse_req(1'b0, 1'b1, 1'b0, "kick_ignored");
    end
    do_tick(1, 1, 0, 0, 0, 0, "after_punch");

    // Simultaneous requests: punch wins, single ack; long strobe = one tick.
    pulse_req(1'b1, 1'b1, 1'b1, "both");
    do_tick(5, 1, 0, 2, 0, 1, "both_start");
    punch_body("both_punch");
    do_tick(1, 1, 0, 0, 0, 0, "after_both");

    // Reset two ticks into a kick.
    pulse_req(1'b0, 1'b1, 1'b1, "kick");
    do_tick(1, 1, 0, 3, 0, 1, "kick_start");
    do_tick(1, 1, 0, 3, 0, 1, "kick1");
    do_tick(1, 1, 0, 3, 0, 1, "kick2");
    @(negedge clk);
    rst        = 1'b1;
    frame_tick = 1'b1;
    #1;
    check("midrst.busy", busy, 0);
    check("midrst.sprite_sel", sprite_sel, 0);
    check("midrst.RyuX", ryu_x, 100);
    check("midrst.frame_idx", frame_idx, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    frame_tick = 1'b0;
    @(negedge clk);
    for (int k = 1; k <= 6; k++) do_tick(1, 1, 100, 0, k / 6, 0, "post_rst");

    // A pending request is discarded by reset.
    pulse_req(1'b1, 1'b0, 1'b1, "punch_pre_rst");
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_tick(1, 1, 100, 0, 0, 0, "pend_discard");

    repeat (4) @(negedge clk);
    check("sb_empty", sb_q.size(), 0);
    check("ack_q_empty", ack_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ryu_anim_controller.md
Name: ryu_anim_controller

Overview:
Per-frame sequencer for the Ryu fighter sprite. It owns Ryu's screen position, current animation (idle pulse, walk, punch, kick) and frame index. It updates them only at frame boundaries so the sprite renderer never tears mid-scan. Its outputs feed the sprite renderer's RyuX/RyuY inputs and the sprite/ROM select logic; action requests come from the keyboard decode.

Parameters:
X_INIT, 100, RyuX after reset
Y_INIT, 250, RyuY after reset (constant; no vertical motion in this block)
X_MIN, 0, leftmost legal RyuX
X_MAX, 527, rightmost legal RyuX (640 - 113 sprite width)
STEP, 2, pixels moved per frame tick while walking
HOLD, 6, frame ticks each animation frame is displayed
IDLE_FRAMES, 4, frames in the idle-pulse loop
WALK_FRAMES, 4, frames in the walk loop
PUNCH_FRAMES, 3, frames in the punch (one-shot)
KICK_FRAMES, 4, frames in the kick (one-shot)

Ports:
vga_clk  in  1  system clock, rising edge
Reset  in  1  asynchronous, active-high reset
frame_tick  in  1  level frame strobe (e.g. vertical-blank flag); rising edge = one tick
move_left  in  1  level, walk-left request
move_right  in  1  level, walk-right request
punch_req  in  1  level, punch request
kick_req  in  1  level, kick request
RyuX  out  10  sprite left edge
RyuY  out  10  sprite top edge
sprite_sel  out  2  0 = IDLE, 1 = WALK, 2 = PUNCH, 3 = KICK
frame_idx  out  2  animation frame within the current sprite
busy  out  1  high while a punch or kick is playing
act_ack  out  1  one-cycle pulse when an action request is accepted

Behaviour:
- Clock and reset: one clock, vga_clk. Reset is asynchronous and active-high.
- Reset values: RyuX = X_INIT, RyuY = Y_INIT, state = IDLE, sprite_sel = 0, frame_idx = 0, hold_cnt = 0, busy = 0, act_ack = 0, both pending flags = 0, tick_prev = 1. Because tick_prev resets to 1, a frame_tick that is already high at reset release is not counted as a tick.
- Tick detection:
  - tick = frame_tick & ~tick_prev; tick_prev is registered every cycle.
  - All state, position and frame outputs update only on the clock edge where tick = 1.
  - Outputs are registered, so they become visible the cycle after the tick edge.
- Request capture runs every cycle, independent of tick:
  - Capture happens only when state is IDLE or WALK and no action is already pending.
  - punch_req = 1 sets punch_pend; otherwise kick_req = 1 sets kick_pend.
  - If both are high together, punch wins.
  - act_ack = 1 for exactly the one cycle following capture.
  - Requests while busy = 1, or while an action is already pending, are ignored and produce no ack.
- Action state machine, IDLE or WALK on a tick:
  - If punch_pend or kick_pend is set: go to PUNCH or KICK, clear the pending flag, set frame_idx = 0, hold_cnt = 0, busy = 1. Position is unchanged.
  - Else, movement:
    - right only: RyuX = min(RyuX + STEP, X_MAX); state = WALK.
    - left only: RyuX = max(RyuX - STEP, X_MIN); state = IDLE → WALK as well (left also walks).
    - neither, or both: state = IDLE; RyuX unchanged.
  - Saturation is computed at 11-bit width so there is no wrap below 0 or above 1023.
  - If state changes between IDLE and WALK: frame_idx = 0, hold_cnt = 0.
  - Otherwise animate: if hold_cnt == HOLD-1, then hold_cnt = 0 and frame_idx = (frame_idx + 1) mod N (N = IDLE_FRAMES or WALK_FRAMES). Else hold_cnt increments.
- Action state machine, PUNCH or KICK on a tick:
  - Position is frozen and move inputs are ignored.
  - hold_cnt and frame_idx advance as above.
  - When frame_idx == N-1 and hold_cnt == HOLD-1: state = IDLE, frame_idx = 0, hold_cnt = 0, busy = 0.
  - One action therefore lasts exactly N*HOLD ticks.
- sprite_sel is the state encoding; RyuY is held at Y_INIT.
- Reset mid-action: everything returns to reset values immediately, and any pending request is discarded.

Test Plan:
- Reset, then 24 ticks with no inputs → sprite_sel = 0; frame_idx steps 0,1,2,3 every 6 ticks and wraps to 0 at tick 24; RyuX = 100 throughout.
- move_right held for 10 ticks → sprite_sel = 1 after tick 1; RyuX = 120 after tick 10; frame_idx = 1 after tick 7.
- RyuX = 526 with move_right held → RyuX = 527 and stays 527. RyuX = 1 with move_left held → RyuX = 0 and stays 0; no wrap either way.
- punch_req pulsed mid-frame → act_ack high for exactly one cycle. Next tick: sprite_sel = 2, busy = 1. After 18 ticks: sprite_sel = 0, busy = 0. A kick_req during the punch produces no ack and no kick.
- punch_req and kick_req asserted in the same cycle → punch is taken (sprite_sel = 2) and only one act_ack occurs. frame_tick held high for 5 cycles counts as one tick.
- Reset asserted 2 ticks into a kick → same cycle: busy = 0, sprite_sel = 0, RyuX = 100. frame_tick high at reset release causes no tick.
